dpram_pingpong_buffer: RTL and testbench

- Two-bank (ping-pong) dual-port RAM between the waveform-buffer reader (writer side) and the readout consumer (reader side).
- The writer fills one bank with 128-bit words, then commits it with a length via `run`. The reader sees that bank as busy, reads it out as 64-bit words, and releases it with `done`.
- The writer can fill the other bank while the reader drains.
- The block sits directly after wvb_reader in the readout path.

---
 rtl/dpram_pingpong_buffer.sv | 102 ++++++++++
 tb/tb_dpram_pingpong_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dpram_pingpong_buffer.sv
// Two-bank ping-pong buffer: the writer fills and commits one bank of wide words
// while the reader drains the other bank as half-width words, then releases it.
module dpram_pingpong_buffer #(
  parameter int P_WR_ADDR_WIDTH = 8,
  parameter int P_WR_DATA_WIDTH = 128,
  parameter int P_RD_DATA_WIDTH = P_WR_DATA_WIDTH / 2,
  parameter int P_LEN_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [P_WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [P_WR_DATA_WIDTH-1:0] wr_din,
  input  logic [P_LEN_WIDTH-1:0]     dpram_len_in,
  input  logic                       run,
  output logic                       wr_busy,
  input  logic [P_WR_ADDR_WIDTH:0]   rd_addr,
  output logic [P_RD_DATA_WIDTH-1:0] rd_dout,
  output logic [P_LEN_WIDTH-1:0]     dpram_len_out,
  input  logic                       done,
  output logic                       rd_busy
);

  localparam int DEPTH = 1 << P_WR_ADDR_WIDTH;

  logic [P_WR_DATA_WIDTH-1:0] mem [2*DEPTH];

  logic [1:0]                 full_q, full_d;
  logic [P_LEN_WIDTH-1:0]     len0_q, len0_d;
  logic [P_LEN_WIDTH-1:0]     len1_q, len1_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_bank_q, rd_bank_d;
  logic [P_RD_DATA_WIDTH-1:0] rd_dout_q, rd_dout_d;

  logic                       wr_fire;
  logic                       commit;
  logic                       release_bank;
  logic [P_WR_DATA_WIDTH-1:0] rd_word;

  assign wr_busy       = full_q[wr_bank_q];
  assign rd_busy       = full_q[rd_bank_q];
  assign dpram_len_out = rd_bank_q ? len1_q : len0_q;
  assign rd_dout       = rd_dout_q;

  assign wr_fire      = wr_en & ~wr_busy;
  assign commit       = run & ~wr_busy;
  assign release_bank = done & rd_busy;

  // commit needs a non-full write bank and release needs a full read bank, so
  // when both fire in one cycle they always touch different banks.
  always_comb begin
    full_d    = full_q;
    len0_d    = len0_q;
    len1_d    = len1_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
      if (wr_bank_q) len1_d = dpram_len_in;
      else           len0_d = dpram_len_in;
      wr_bank_d = ~wr_bank_q;
    end
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d = ~rd_bank_q;
    end
  end

  // Reader address LSB selects the low or high half of the wide writer word.
  always_comb begin
    rd_word   = mem[{rd_bank_q, rd_addr[P_WR_ADDR_WIDTH:1]}];
    rd_dout_d = rd_addr[0] ? rd_word[P_WR_DATA_WIDTH-1:P_RD_DATA_WIDTH]
                           : rd_word[P_RD_DATA_WIDTH-1:0];
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; only the
  // control state and the output register are cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank_q, wr_addr}] <= wr_din;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= '0;
      len0_q    <= '0;
      len1_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_dout_q <= '0;
    end else begin
      full_q    <= full_d;
      len0_q    <= len0_d;
      len1_q    <= len1_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_dout_q <= rd_dout_d;
    end
  end

endmodule

// File: tb/tb_dpram_pingpong_buffer.sv
// Directed bench for dpram_pingpong_buffer: commit/release ordering, blocking,
// width mapping, simultaneous run/done and asynchronous reset.
module tb_dpram_pingpong_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [127:0] wr_din;
  logic [15:0]  dpram_len_in;
  logic         run;
  logic         wr_busy;
  logic [8:0]   rd_addr;
  logic [63:0]  rd_dout;
  logic [15:0]  dpram_len_out;
  logic         done;
  logic         rd_busy;

  int checks = 0;
  int errors = 0;

  dpram_pingpong_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_din        (wr_din),
    .dpram_len_in  (dpram_len_in),
    .run           (run),
    .wr_busy       (wr_busy),
    .rd_addr       (rd_addr),
    .rd_dout       (rd_dout),
    .dpram_len_out (dpram_len_out),
    .done          (done),
    .rd_busy       (rd_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [127:0] d);
    wr_en = 1'b1; wr_addr = a; wr_din = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_run(input logic [15:0] len);
    run = 1'b1; dpram_len_in = len;
    tick();
    run = 1'b0;
  endtask

  task automatic do_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a, input logic [63:0] exp, input string tag);
    rd_addr = a;
    tick();
    check(tag, rd_dout, exp);
  endtask

  function automatic logic [127:0] pat(input logic [15:0] a);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = 16'hA000 + a;
    lo = 16'hB000 + a;
    return {hi, hi, hi, hi, lo, lo, lo, lo};
  endfunction

  initial begin
    logic [15:0] w;
    logic [63:0] exp64;

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_din = '0; dpram_len_in = '0;
    run = 1'b0; rd_addr = '0; done = 1'b0;

    // Reset and idle
    tick(); tick();
    check("rst_wr_busy", wr_busy, 0);
    check("rst_rd_busy", rd_busy, 0);
    check("rst_len_out", dpram_len_out, 0);
    check("rst_rd_dout", rd_dout, 0);
    rst = 1'b1;
    check("idle_wr_busy", wr_busy, 0);
    check("idle_rd_busy", rd_busy, 0);

    // Fill bank0 with 4 words, commit len 16, read 8 half-words back
    for (int a = 0; a < 4; a++) do_write(8'(a), pat(16'(a)));
    check("pre_run_rd_busy", rd_busy, 0);
    do_run(16'd16);
    check("run0_rd_busy", rd_busy, 1);
    check("run0_len_out", dpram_len_out, 16);
    check("run0_wr_busy", wr_busy, 0);
    for (int i = 0; i < 8; i++) begin
      w = 16'(i >> 1);
      exp64 = (i % 2 == 1) ? {4{16'hA000 + w}} : {4{16'hB000 + w}};
      do_read(9'(i), exp64, $sformatf("read_b0_%0d", i));
    end

    // Release bank0; read pointer moves to the empty bank1
    do_done();
    check("rel0_rd_busy", rd_busy, 0);
    check("rel0_wr_busy", wr_busy, 0);

    // Commit bank1 (len 8) with a write in the same cycle, then bank0 (len 24)
    wr_en = 1'b1; wr_addr = 8'd5; wr_din = pat(16'h0050);
    do_run(16'd8);
    wr_en = 1'b0;
    check("c1_rd_busy", rd_busy, 1);
    check("c1_len_out", dpram_len_out, 8);
    check("c1_wr_busy", wr_busy, 0);
    do_run(16'd24);
    check("both_full_wr_busy", wr_busy, 1);
    check("both_full_len_out", dpram_len_out, 8);

    // Writes and commits while both banks are full must be ignored
    do_write(8'd0, {128{1'b1}});
    do_run(16'd99);
    check("blocked_wr_busy", wr_busy, 1);
    check("blocked_len_out", dpram_len_out, 8);
    check("blocked_rd_busy", rd_busy, 1);
    do_read(9'd10, {4{16'hB050}}, "read_wr_with_run");

    // First done: bank0 (len 24) becomes the read bank, writer unblocks
    do_done();
    check("d1_rd_busy", rd_busy, 1);
    check("d1_len_out", dpram_len_out, 24);
    check("d1_wr_busy", wr_busy, 0);
    do_read(9'd0, {4{16'hB000}}, "read_blocked_write_absent");
    do_read(9'd7, {4{16'hA003}}, "read_b0_addr3_hi");

    // run and done in the same cycle: bank0 freed, bank1 committed with len 40
    do_write(8'd1, pat(16'h0011));
    run = 1'b1; dpram_len_in = 16'd40; done = 1'b1;
    tick();
    run = 1'b0; done = 1'b0;
    check("sim_rd_busy", rd_busy, 1);
    check("sim_len_out", dpram_len_out, 40);
    check("sim_wr_busy", wr_busy, 0);
    do_read(9'd3, {4{16'hA011}}, "sim_read_b1_hi");

    // Second done empties everything; a spurious done is then ignored
    do_done();
    check("d2_rd_busy", rd_busy, 0);
    check("d2_len_out", dpram_len_out, 24);
    do_done();
    check("idle_done_rd_busy", rd_busy, 0);
    check("idle_done_wr_busy", wr_busy, 0);

    // Fill both banks, start reading, then reset asynchronously mid-cycle
    do_run(16'd4);
    do_run(16'd12);
    check("pre_rst_wr_busy", wr_busy, 1);
    check("pre_rst_len_out", dpram_len_out, 4);
    do_read(9'd1, {4{16'hA000}}, "pre_rst_read");
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_wr_busy", wr_busy, 0);
    check("async_rst_rd_busy", rd_busy, 0);
    check("async_rst_len_out", dpram_len_out, 0);
    check("async_rst_rd_dout", rd_dout, 0);
    tick();
    rst = 1'b1;
    do_done();
    check("post_rst_done_rd_busy", rd_busy, 0);
    check("post_rst_done_wr_busy", wr_busy, 0);
    do_run(16'd7);
    check("post_rst_run_rd_busy", rd_busy, 1);
    check("post_rst_run_len_out", dpram_len_out, 7);
    check("post_rst_run_wr_busy", wr_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
